// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the performance aggregation slice.
package riscv_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    UPDATE
  } perf_agg_state_e;

  localparam int unsigned DEFAULT_NUM_CORES          = 4;
  localparam int unsigned DEFAULT_PERF_WINDOW_CYCLES = 1024;
  localparam int unsigned DEFAULT_IPC_FRAC_BITS      = 8;
  localparam int unsigned PERF_HIT_RATE_EMPTY        = 100;

  // Number of set bits in a strobe vector (up to 32 cores).
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/perf_restoring_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH-cycle latency.
// done_o is high in the cycle performing the last step; quotient_o is valid
// from the following cycle until the next start.
module perf_restoring_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic [CNT_W-1:0] step_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_d;
  logic             ge;
  logic             unused_rem_msb;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
  end

  // Remainder is always below the divisor, so its top bit is never needed.
  assign unused_rem_msb = rem_d[WIDTH];

  assign done_o     = busy_q && (step_q == CNT_W'(WIDTH - 1));
  assign quotient_o = quo_q;

  // Operand load on start, then WIDTH iterations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], ge};
      if (step_q == CNT_W'(WIDTH - 1)) begin
        busy_q <= 1'b0;
      end else begin
        step_q <= step_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_core_perf_aggregator.sv
// Windowed per-core event aggregator producing IPC, L1 hit rate,
// stall-bottleneck and activity snapshots once per window.
module multi_core_perf_aggregator
  import riscv_core_pkg::*;
#(
  parameter int unsigned NUM_CORES     = DEFAULT_NUM_CORES,
  parameter int unsigned WINDOW_CYCLES = DEFAULT_PERF_WINDOW_CYCLES,
  parameter int unsigned IPC_FRAC_BITS = DEFAULT_IPC_FRAC_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 perf_enable_i,
  input  logic [NUM_CORES-1:0] instr_retired_i,
  input  logic [NUM_CORES-1:0] l1_access_i,
  input  logic [NUM_CORES-1:0] l1_hit_i,
  input  logic [NUM_CORES-1:0] stall_i,
  input  logic [NUM_CORES-1:0] core_active_i,
  output logic [31:0]          current_ipc_o,
  output logic [7:0]           cache_hit_rate_l1_o,
  output logic                 pipeline_bottleneck_o,
  output logic                 any_core_active_o,
  output logic                 perf_valid_o
);

  localparam int unsigned ACC_W    = $clog2(NUM_CORES * WINDOW_CYCLES + 1);
  localparam int unsigned DIV_W    = ACC_W + 7;
  localparam int unsigned WIN_LOG2 = $clog2(WINDOW_CYCLES);
  localparam int unsigned CNT_W    = WIN_LOG2;
  localparam int unsigned IPC_W    = ACC_W + IPC_FRAC_BITS;
  localparam logic [ACC_W-1:0] STALL_HALF = ACC_W'((NUM_CORES * WINDOW_CYCLES) / 2);

  // The divide/update sequence must finish before the next window end.
  if (((WINDOW_CYCLES & (WINDOW_CYCLES - 1)) != 0) || (WINDOW_CYCLES < 2 * DIV_W + 4)) begin : g_bad_window
    $error("WINDOW_CYCLES must be a power of two and at least 2*DIV_W+4");
  end

  perf_agg_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] ret_acc_q, acc_acc_q, hit_acc_q, stall_acc_q;
  logic [ACC_W-1:0] ret_acc_d, acc_acc_d, hit_acc_d, stall_acc_d;
  logic [ACC_W-1:0] ret_snap_q, acc_snap_q, stall_snap_q;
  logic             win_end;
  logic             div_start, div_done;
  logic [DIV_W-1:0] div_dividend, div_quo;
  logic [IPC_W-1:0] ipc_full;
  logic [31:0]      ipc_d;
  logic [7:0]       rate_d;
  logic             unused_quo_hi;

  logic [31:0] ipc_q;
  logic [7:0]  rate_q;
  logic        bottleneck_q, active_q, valid_q;

  // Accumulator next values include the current cycle's strobes.
  always_comb begin
    ret_acc_d   = ret_acc_q   + ACC_W'(popcount(32'(instr_retired_i)));
    acc_acc_d   = acc_acc_q   + ACC_W'(popcount(32'(l1_access_i)));
    hit_acc_d   = hit_acc_q   + ACC_W'(popcount(32'(l1_hit_i & l1_access_i)));
    stall_acc_d = stall_acc_q + ACC_W'(popcount(32'(stall_i & core_active_i)));
  end

  assign win_end      = perf_enable_i && (cnt_q == CNT_W'(WINDOW_CYCLES - 1));
  assign div_start    = (state_q == IDLE) && win_end;
  assign div_dividend = DIV_W'(hit_acc_d) * DIV_W'(PERF_HIT_RATE_EMPTY);

  // Snapshot-derived output values, computed from registered snapshots.
  always_comb begin
    ipc_full = (IPC_W'(ret_snap_q) << IPC_FRAC_BITS) >> WIN_LOG2;
    ipc_d    = 32'(ipc_full);
    rate_d   = (acc_snap_q == '0) ? 8'(PERF_HIT_RATE_EMPTY) : div_quo[7:0];
  end

  // Quotient never exceeds 100, so only the low byte is consumed.
  assign unused_quo_hi = ^div_quo[DIV_W-1:8];

  // Window counter and event accumulators; cleared at window end and while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      ret_acc_q   <= '0;
      acc_acc_q   <= '0;
      hit_acc_q   <= '0;
      stall_acc_q <= '0;
    end else if (!perf_enable_i || win_end) begin
      cnt_q       <= '0;
      ret_acc_q   <= '0;
      acc_acc_q   <= '0;
      hit_acc_q   <= '0;
      stall_acc_q <= '0;
    end else begin
      cnt_q       <= cnt_q + CNT_W'(1);
      ret_acc_q   <= ret_acc_d;
      acc_acc_q   <= acc_acc_d;
      hit_acc_q   <= hit_acc_d;
      stall_acc_q <= stall_acc_d;
    end
  end

  perf_restoring_divider #(
    .WIDTH(DIV_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (DIV_W'(acc_acc_d)),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Snapshot/divide/update sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ret_snap_q   <= '0;
      acc_snap_q   <= '0;
      stall_snap_q <= '0;
      ipc_q        <= '0;
      rate_q       <= '0;
      bottleneck_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_end) begin
            ret_snap_q   <= ret_acc_d;
            acc_snap_q   <= acc_acc_d;
            stall_snap_q <= stall_acc_d;
            state_q      <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          ipc_q        <= ipc_d;
          rate_q       <= rate_d;
          bottleneck_q <= (stall_snap_q > STALL_HALF);
          valid_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Activity flag tracks the cores every cycle, independent of enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
    end else begin
      active_q <= |core_active_i;
    end
  end

  assign current_ipc_o         = ipc_q;
  assign cache_hit_rate_l1_o   = rate_q;
  assign pipeline_bottleneck_o = bottleneck_q;
  assign any_core_active_o     = active_q;
  assign perf_valid_o          = valid_q;

endmodule

// File: tb/tb_multi_core_perf_aggregator.sv
// Directed bench for multi_core_perf_aggregator (4 cores, 64-cycle window).
module tb_multi_core_perf_aggregator;

  localparam int unsigned NC   = 4;
  localparam int unsigned WIN  = 64;
  localparam int unsigned FRAC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NC-1:0] ret, acc, hit, stall, act;
  logic [31:0]   ipc;
  logic [7:0]    rate;
  logic          bneck, active, valid;

  int total = 0;
  int bad   = 0;
  int lat;
  int seen;
  logic [31:0] seen_ipc;
  logic        prev_act;
  logic [NC-1:0] act_k;

  always #5 clk = ~clk;

  multi_core_perf_aggregator #(
    .NUM_CORES     (NC),
    .WINDOW_CYCLES (WIN),
    .IPC_FRAC_BITS (FRAC)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .perf_enable_i         (en),
    .instr_retired_i       (ret),
    .l1_access_i           (acc),
    .l1_hit_i              (hit),
    .stall_i               (stall),
    .core_active_i         (act),
    .current_ipc_o         (ipc),
    .cache_hit_rate_l1_o   (rate),
    .pipeline_bottleneck_o (bneck),
    .any_core_active_o     (active),
    .perf_valid_o          (valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NC-1:0] r, input logic [NC-1:0] a, input logic [NC-1:0] h,
                       input logic [NC-1:0] s, input logic [NC-1:0] c);
    ret = r; acc = a; hit = h; stall = s; act = c;
    tick();
  endtask

  task automatic quiet();
    ret = '0; acc = '0; hit = '0; stall = '0;
  endtask

  // Called in the cycle after the last window cycle; returns pulse offset from it.
  task automatic wait_valid(output int l);
    l = 1;
    while (valid !== 1'b1 && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic finish_window(input string tag, input logic [31:0] e_ipc,
                               input logic [7:0] e_rate, input logic e_bn);
    en = 1'b0;
    quiet();
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_ipc"}, ipc, e_ipc);
    check({tag, "_rate"}, 32'(rate), 32'(e_rate));
    check({tag, "_bneck"}, 32'(bneck), 32'(e_bn));
    tick();
    check({tag, "_pulse_end"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    ret = '0; acc = '0; hit = '0; stall = '0; act = 4'hF;
    tick(); tick();
    // Reset state
    check("rst_ipc", ipc, 32'd0);
    check("rst_rate", 32'(rate), 32'd0);
    check("rst_bneck", 32'(bneck), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("active_after_rst", 32'(active), 32'd1);

    // All cores retire every cycle: 256 retires -> 4.0; no accesses -> 100
    en = 1'b1;
    for (int c = 0; c < 64; c++) drive(4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    finish_window("full_ipc", 32'h400, 8'd100, 1'b0);
    check("ipc_hold", ipc, 32'h400);

    // 200 accesses, 150 hits; hits without access ignored -> 75
    en = 1'b1;
    for (int c = 0; c < 64; c++)
      drive(4'h0, (c < 50) ? 4'hF : 4'h0,
            (c < 37) ? 4'hF : (c == 37) ? 4'h3 : (c >= 50) ? 4'hF : 4'h0,
            4'h0, 4'hF);
    finish_window("hit75", 32'h0, 8'd75, 1'b0);

    // 3 accesses, 2 hits -> 66; 10 retires -> 10*256/64 = 40
    en = 1'b1;
    for (int c = 0; c < 64; c++)
      drive((c < 10) ? 4'h1 : 4'h0, (c == 0) ? 4'h7 : 4'h0,
            (c == 0) ? 4'h3 : 4'h0, 4'h0, 4'hF);
    finish_window("hit66", 32'h28, 8'd66, 1'b0);

    // 129 active stall core-cycles -> bottleneck
    en = 1'b1;
    for (int c = 0; c < 64; c++)
      drive(4'h0, 4'h0, 4'h0, (c < 32) ? 4'hF : (c == 32) ? 4'h1 : 4'h0, 4'hF);
    finish_window("stall129", 32'h0, 8'd100, 1'b1);

    // 128 active stalls plus inactive stalls -> not a bottleneck
    en = 1'b1;
    for (int c = 0; c < 64; c++)
      drive(4'h0, 4'h0, 4'h0, (c < 48) ? 4'hF : 4'h0,
            (c >= 32 && c < 48) ? 4'h0 : 4'hF);
    finish_window("stall128", 32'h0, 8'd100, 1'b0);

    // Window boundary: 4 retires on last cycle of A, 2 on first cycle of B
    en = 1'b1;
    for (int c = 0; c < 64; c++) drive((c == 63) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    seen = -1;
    seen_ipc = '0;
    for (int c = 0; c < 64; c++) begin
      drive((c == 0) ? 4'h3 : 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
      if (valid === 1'b1 && seen < 0) begin
        seen = c;
        seen_ipc = ipc;
      end
    end
    check("bound_a_when", 32'(seen), 32'd16);
    check("bound_a_ipc", seen_ipc, 32'h10);
    finish_window("bound_b", 32'h8, 8'd100, 1'b0);

    // Reset mid-DIVIDE discards the snapshot
    en = 1'b1;
    for (int c = 0; c < 64; c++) drive(4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    en = 1'b0;
    quiet();
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_ipc", ipc, 32'd0);
    check("midrst_rate", 32'(rate), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    ret = 4'h5;
    lat = 0;
    while (valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("postrst_latency", 32'(lat), 32'd81);
    check("postrst_ipc", ipc, 32'h200);
    en = 1'b0;
    quiet();
    tick(); tick();

    // Enable drop mid-window while the previous update is in flight
    en = 1'b1;
    for (int c = 0; c < 64; c++) drive(4'h1, 4'h0, 4'h0, 4'h0, 4'hF);
    for (int c = 0; c < 9; c++) drive(4'hF, 4'h0, 4'h0, 4'h0, 4'hF);
    en = 1'b0;
    seen = -1;
    seen_ipc = '0;
    prev_act = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      act_k = (k % 2 == 1) ? 4'h0 : 4'h4;
      ret = 4'hF; act = act_k;
      check("active_lag_pre", 32'(active), 32'(prev_act));
      tick();
      check("active_lag_post", 32'(active), 32'(|act_k));
      prev_act = |act_k;
      if (valid === 1'b1 && seen < 0) begin
        seen = k;
        seen_ipc = ipc;
      end
    end
    check("inflight_when", 32'(seen), 32'd8);
    check("inflight_ipc", seen_ipc, 32'h100);
    en = 1'b1;
    for (int c = 0; c < 64; c++) drive(4'h3, 4'h0, 4'h0, 4'h0, 4'hF);
    finish_window("restart", 32'h200, 8'd100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/multi_core_perf_aggregator.md
# multi_core_perf_aggregator

Windowed performance aggregator that sits directly upstream of the multi-core management block. It collects per-core retire, L1 access/hit, stall and activity strobes, and accumulates them over a fixed cycle window. At each window end it produces a coherent snapshot of system IPC, L1 hit rate, bottleneck flag and activity flag. These values drive the system controller's power/performance policy inputs.

## Interface
- `NUM_CORES`, default `DEFAULT_NUM_CORES` (4): number of cores reporting strobes.
- `WINDOW_CYCLES`, default 1024: measurement window length; power of two, ≥ 2·DIV_W+4.
- `IPC_FRAC_BITS`, default 8: fractional bits of the fixed-point IPC output.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `perf_enable_i`  in  1  counting enable.
- `instr_retired_i`  in  NUM_CORES  per-core retire strobe, one per cycle max.
- `l1_access_i`  in  NUM_CORES  per-core L1 access strobe.
- `l1_hit_i`  in  NUM_CORES  per-core L1 hit strobe; counted only with the matching access bit.
- `stall_i`  in  NUM_CORES  per-core pipeline stall strobe.
- `core_active_i`  in  NUM_CORES  per-core active level.
- `current_ipc_o`  out  32  system IPC, unsigned, IPC_FRAC_BITS fractional bits, zero-extended.
- `cache_hit_rate_l1_o`  out  8  L1 hit rate in percent, 0..100.
- `pipeline_bottleneck_o`  out  1  stall-dominated window flag.
- `any_core_active_o`  out  1  registered OR of `core_active_i`.
- `perf_valid_o`  out  1  one-cycle pulse when the outputs above update.

## Operation
- Derived widths: `ACC_W = $clog2(NUM_CORES*WINDOW_CYCLES+1)`; `DIV_W = ACC_W+7`.
- Each enabled cycle, add to the accumulators:
  - retire accumulator: popcount(`instr_retired_i`);
  - access accumulator: popcount(`l1_access_i`);
  - hit accumulator: popcount(`l1_hit_i & l1_access_i`);
  - stall accumulator: popcount(`stall_i & core_active_i`).
- Cycle counter runs 0..WINDOW_CYCLES-1 and wraps to 0.
- Last window cycle: the snapshot includes that cycle's strobes. The accumulators restart from zero on the next cycle. No event is lost or double-counted.
- FSM:
  - IDLE: at window end, load the snapshot and go to DIVIDE.
  - DIVIDE: restoring division of hits·100 by accesses, DIV_W cycles, one quotient bit per cycle; then go to UPDATE.
  - UPDATE: register all outputs, pulse `perf_valid_o`, go to IDLE.
- Output values:
  - `current_ipc_o = (retired_snap << IPC_FRAC_BITS) >> log2(WINDOW_CYCLES)`.
  - Hit rate: accesses_snap == 0 gives 100; otherwise the truncated quotient.
  - `pipeline_bottleneck_o = stall_snap > (NUM_CORES*WINDOW_CYCLES)/2`, strictly greater.
- Accumulators are sized so they never overflow within a window; no saturation logic is needed.
- `perf_enable_i` low: cycle counter and accumulators are held at zero. An in-flight DIVIDE/UPDATE completes normally. A window restarts at count 0 on the first enabled cycle.
- `any_core_active_o` updates every cycle regardless of enable or FSM state.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters and accumulators 0. `cache_hit_rate_l1_o` resets to 0, not 100.
- Let cycle N be the last window cycle:
  - DIVIDE occupies cycles N+1..N+DIV_W;
  - UPDATE is cycle N+DIV_W+1;
  - new outputs and the `perf_valid_o` pulse appear in cycle N+DIV_W+2.
- Outputs hold their values between updates; `perf_valid_o` is high for exactly one cycle per window.
- The next window end always finds the FSM in IDLE; this is guaranteed by the WINDOW_CYCLES constraint and checked by an elaboration-time assertion.
- Reset asserted mid-DIVIDE: the snapshot is discarded and no pulse is produced. The first window after reset release is full length.
- `any_core_active_o`: one-cycle latency from `core_active_i`.

## Structure
- `riscv_core_pkg` holds:
  - `perf_agg_state_e` (IDLE, DIVIDE, UPDATE);
  - `DEFAULT_PERF_WINDOW_CYCLES` (1024);
  - `DEFAULT_IPC_FRAC_BITS` (8);
  - `PERF_HIT_RATE_EMPTY` (100).
- Sub-module `perf_restoring_divider`:
  - parameterised width;
  - `start`/`done` handshake;
  - fixed DIV_W-cycle latency;
  - outputs quotient only.
- Popcount is a package function.

## Test plan
Bench uses NUM_CORES=4, WINDOW_CYCLES=64, IPC_FRAC_BITS=8, so ACC_W=9 and DIV_W=16.

- All four cores retire every cycle for one window → `current_ipc_o`=0x400 (4.0), `perf_valid_o` pulses exactly 18 cycles after the last window cycle.
- 200 accesses, 150 hits in a window → `cache_hit_rate_l1_o`=75. A window with 3 accesses and 2 hits → 66 (truncated). A window with 0 accesses → 100.
- Stall boundary:
  - 129 active stall core-cycles → `pipeline_bottleneck_o`=1;
  - 128 → 0;
  - stalls with `core_active_i`=0 are not counted.
- Strobes on the last window cycle and the first cycle of the next window → each is counted exactly once, in its own window.
- Reset pulse mid-DIVIDE → all outputs 0, no `perf_valid_o`; the next pulse follows 64 cycles after release plus 18.
- `perf_enable_i` low for 10 cycles mid-window with retires ongoing → counting restarts at 0. The in-flight update still pulses. `any_core_active_o` keeps tracking `core_active_i` with 1-cycle lag.
